// File: rtl/gray_stream_decoder_pkg.sv
// gray_pkg: shared types and helpers for the gray-coded position link.
//   step_t  : step classification between consecutive samples
//   state_t : decoder tracking state
//   gray2bin: gray-to-binary conversion over GRAY_MAX_W bits; narrower
//             words are zero-extended, which leaves their low bits unaffected.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        ERR  = 2'b11
    } step_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Each binary bit is the XOR of all gray bits at and above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_stream_decoder_gray2bin_comb.sv
// gray2bin_comb: purely combinational W-bit gray-to-binary converter.
// Ports:
//   gray : W-bit gray-coded input
//   bin  : W-bit binary result
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder: accepts gray-coded samples over valid/ready, converts
// them to binary and classifies the step from the previous sample as HOLD,
// UP, DOWN or ERR. Keeps a wrapping signed position and a saturating error
// count. One output register, one cycle of latency, full throughput.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   clear               : drop history, zero pos and err_count, discard input
//   in_valid/in_ready   : input handshake, in_gray is the sample
//   out_valid/out_ready : output handshake
//   out_bin             : binary value of the accepted sample
//   out_step            : 00 HOLD, 01 UP, 10 DOWN, 11 ERR
//   out_first           : first sample after reset/clear (step is HOLD)
//   pos                 : signed position accumulator (wraps)
//   err_count           : number of ERR steps (saturates)
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int W     = 4,
    parameter int POS_W = 16,
    parameter int ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_gray,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_bin,
    output logic [1:0]              out_step,
    output logic                    out_first,
    output logic signed [POS_W-1:0] pos,
    output logic [ERR_W-1:0]        err_count
);

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] c);
        return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
    endfunction

    function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                          input step_t s);
        case (s)
            UP:      return p + POS_W'(1);
            DOWN:    return p - POS_W'(1);
            default: return p;
        endcase
    endfunction

    state_t                   state_p1, state_nxt;
    logic [W-1:0]             prev_bin_p1;
    logic                     vld_p1;
    logic [W-1:0]             bin_p1;
    step_t                    step_p1, step_nxt;
    logic                     first_p1, first_nxt;
    logic signed [POS_W-1:0]  pos_p1;
    logic [ERR_W-1:0]         err_p1, err_nxt;

    logic [W-1:0]             bin_p0;
    logic [W-1:0]             delta_p0;
    logic                     accept_p0;

    // ---- stage p0: combinational conversion, handshake and classification ----
    gray2bin_comb #(.W(W)) u_gray2bin (
        .gray (in_gray),
        .bin  (bin_p0)
    );

    // clear blocks the input so a sample offered during clear is never taken.
    assign in_ready  = !clear && (!vld_p1 || out_ready);
    assign accept_p0 = in_valid && in_ready;
    assign delta_p0  = bin_p0 - prev_bin_p1;

    always_comb begin
        state_nxt = state_p1;
        step_nxt  = HOLD;
        first_nxt = 1'b0;
        err_nxt   = err_p1;
        case (state_p1)
            IDLE: begin
                first_nxt = 1'b1;
                state_nxt = TRACK;
            end
            TRACK: begin
                if (delta_p0 == '0) begin
                    step_nxt = HOLD;
                end else if (delta_p0 == W'(1)) begin
                    step_nxt = UP;
                end else if (delta_p0 == {W{1'b1}}) begin
                    step_nxt = DOWN;
                end else begin
                    step_nxt = ERR;
                    err_nxt  = err_sat_inc(err_p1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: output register and tracking state ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1    <= IDLE;
            prev_bin_p1 <= '0;
            vld_p1      <= 1'b0;
            bin_p1      <= '0;
            step_p1     <= HOLD;
            first_p1    <= 1'b0;
            pos_p1      <= '0;
            err_p1      <= '0;
        end else if (clear) begin
            state_p1 <= IDLE;
            vld_p1   <= 1'b0;
            pos_p1   <= '0;
            err_p1   <= '0;
        end else if (accept_p0) begin
            state_p1    <= state_nxt;
            prev_bin_p1 <= bin_p0;
            vld_p1      <= 1'b1;
            bin_p1      <= bin_p0;
            step_p1     <= step_nxt;
            first_p1    <= first_nxt;
            pos_p1      <= pos_step(pos_p1, step_nxt);
            err_p1      <= err_nxt;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_bin   = bin_p1;
    assign out_step  = step_p1;
    assign out_first = first_p1;
    assign pos       = pos_p1;
    assign err_count = err_p1;

endmodule
